// File: rtl/text_writer.sv
// -----------------------------------------------------------------------------
// text_writer
//
// Turns a byte stream into terminal text for the 64x16 character generator.
// It tracks a cursor, writes glyph codes into the character buffer and scrolls
// by moving the buffer's first-row pointer, then blanking the line that has just
// been exposed. The whole buffer is cleared after every reset.
//
// Ports
//   clk                   pixel clock (same domain as the character generator)
//   clr                   asynchronous reset, active-high
//   char_in[7:0]          incoming byte
//   char_valid            char_in is valid
//   char_ready            a byte can be accepted this cycle (combinational)
//   buffer_waddr[9:0]     write address {phys_row[3:0], col[5:0]}
//   buffer_din[7:0]       write data
//   buffer_wen            write strobe, at most one write per cycle
//   buffer_first_row[3:0] physical row shown as the top line
//   buffer_first_row_wen  single-cycle load strobe for buffer_first_row
//   cursor_row[3:0]       logical cursor row, 0 = top line on screen
//   cursor_col[5:0]       cursor column
//
// Build option
//   TEXT_WRITER_AUTOWRAP_EN  when defined, a printable at column 63 wraps to the
//                            next line and may scroll; otherwise the cursor
//                            saturates at column 63.
// -----------------------------------------------------------------------------
module text_writer #(
    parameter logic [7:0] FILL_CHAR = 8'h20,
    parameter int         TAB_WIDTH = 8
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [7:0] char_in,
    input  logic       char_valid,
    output logic       char_ready,
    output logic [9:0] buffer_waddr,
    output logic [7:0] buffer_din,
    output logic       buffer_wen,
    output logic [3:0] buffer_first_row,
    output logic       buffer_first_row_wen,
    output logic [3:0] cursor_row,
    output logic [5:0] cursor_col
);

    localparam logic [1:0] CLEAR_ALL  = 2'd0;
    localparam logic [1:0] IDLE       = 2'd1;
    localparam logic [1:0] CLEAR_LINE = 2'd2;

    localparam logic [6:0] TAB_MASK = 7'(TAB_WIDTH - 1);

    logic [1:0] state;
    logic [9:0] all_cnt;
    logic [6:0] line_cnt;
    logic [3:0] first_row;
    logic [3:0] clear_row;
    logic [3:0] phys_row;
    logic       accept;
    logic       is_print;
    logic       lf_req;
    logic       scroll;

`ifdef TEXT_WRITER_AUTOWRAP_EN
    logic       pend_wen;
    logic [9:0] pend_addr;
    logic [7:0] pend_din;
`endif

    // Next tab stop strictly right of col, saturating at the last column.
    function automatic logic [5:0] tab_stop(input logic [5:0] col);
        logic [6:0] nxt;
        nxt = ({1'b0, col} | TAB_MASK) + 7'd1;
        return nxt[6] ? 6'd63 : nxt[5:0];
    endfunction

    // Column advance after a printable, saturating at the last column.
    function automatic logic [5:0] col_advance(input logic [5:0] col);
        return (col == 6'd63) ? 6'd63 : col + 6'd1;
    endfunction

    assign char_ready       = (state == IDLE);
    assign accept           = char_valid && char_ready;
    assign phys_row         = first_row + cursor_row;
    assign is_print         = (char_in >= 8'h20) && (char_in <= 8'h7E);
    assign buffer_first_row = first_row;

    always_comb begin
        lf_req = accept && (char_in == 8'h0A);
`ifdef TEXT_WRITER_AUTOWRAP_EN
        if (accept && is_print && cursor_col == 6'd63)
            lf_req = 1'b1;
`endif
        scroll = lf_req && (cursor_row == 4'd15);
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state                <= CLEAR_ALL;
            all_cnt              <= 10'd0;
            line_cnt             <= 7'd0;
            first_row            <= 4'd0;
            clear_row            <= 4'd0;
            cursor_row           <= 4'd0;
            cursor_col           <= 6'd0;
            buffer_wen           <= 1'b0;
            buffer_first_row_wen <= 1'b0;
            buffer_waddr         <= 10'd0;
            buffer_din           <= 8'd0;
`ifdef TEXT_WRITER_AUTOWRAP_EN
            pend_wen             <= 1'b0;
            pend_addr            <= 10'd0;
            pend_din             <= 8'd0;
`endif
        end else begin
            buffer_wen           <= 1'b0;
            buffer_first_row_wen <= 1'b0;
            case (state)
                CLEAR_ALL: begin
                    buffer_wen   <= 1'b1;
                    buffer_waddr <= all_cnt;
                    buffer_din   <= FILL_CHAR;
                    all_cnt      <= all_cnt + 10'd1;
                    if (all_cnt == 10'd1023)
                        state <= IDLE;
                end

                CLEAR_LINE: begin
                    // line_cnt[6] marks that all 64 columns have been blanked.
                    if (line_cnt[6]) begin
                        state <= IDLE;
`ifdef TEXT_WRITER_AUTOWRAP_EN
                        // A wrapping printable that triggered the scroll is
                        // written here, after the line clear has finished.
                        if (pend_wen) begin
                            buffer_wen   <= 1'b1;
                            buffer_waddr <= pend_addr;
                            buffer_din   <= pend_din;
                            pend_wen     <= 1'b0;
                        end
`endif
                    end else begin
                        buffer_wen   <= 1'b1;
                        buffer_waddr <= {clear_row, line_cnt[5:0]};
                        buffer_din   <= FILL_CHAR;
                        line_cnt     <= line_cnt + 7'd1;
                    end
                end

                IDLE: begin
                    if (accept) begin
                        if (is_print) begin
                            buffer_wen   <= 1'b1;
                            buffer_waddr <= {phys_row, cursor_col};
                            buffer_din   <= char_in;
                        end

                        case (char_in)
                            8'h0D: cursor_col <= 6'd0;
                            8'h08: if (cursor_col != 6'd0) cursor_col <= cursor_col - 6'd1;
                            8'h09: cursor_col <= tab_stop(cursor_col);
                            default: begin
                                if (is_print) begin
`ifdef TEXT_WRITER_AUTOWRAP_EN
                                    cursor_col <= (cursor_col == 6'd63) ? 6'd0 : cursor_col + 6'd1;
`else
                                    cursor_col <= col_advance(cursor_col);
`endif
                                end
                            end
                        endcase

                        if (scroll) begin
                            // Old top row becomes the new bottom line; blank it
                            // starting with column 0 in the same cycle as the
                            // pointer strobe. This overrides any printable write.
                            first_row            <= first_row + 4'd1;
                            buffer_first_row_wen <= 1'b1;
                            clear_row            <= first_row;
                            state                <= CLEAR_LINE;
                            buffer_wen           <= 1'b1;
                            buffer_waddr         <= {first_row, 6'd0};
                            buffer_din           <= FILL_CHAR;
                            line_cnt             <= 7'd1;
`ifdef TEXT_WRITER_AUTOWRAP_EN
                            pend_wen             <= is_print;
                            pend_addr            <= {phys_row, cursor_col};
                            pend_din             <= char_in;
`endif
                        end else if (lf_req) begin
                            cursor_row <= cursor_row + 4'd1;
                        end
                    end
                end

                default: state <= CLEAR_ALL;
            endcase
        end
    end

endmodule

// File: tb/tb_text_writer.sv
// -----------------------------------------------------------------------------
// tb_text_writer
//
// Directed self-checking bench for text_writer in its default build (no
// autowrap). Drives bytes on the falling edge and samples outputs on the
// falling edge, one cycle after the accepting rising edge.
// -----------------------------------------------------------------------------
module tb_text_writer;

    logic       clk = 1'b0;
    logic       clr;
    logic [7:0] char_in;
    logic       char_valid;
    logic       char_ready;
    logic [9:0] buffer_waddr;
    logic [7:0] buffer_din;
    logic       buffer_wen;
    logic [3:0] buffer_first_row;
    logic       buffer_first_row_wen;
    logic [3:0] cursor_row;
    logic [5:0] cursor_col;

    int tests = 0;
    int fails = 0;

    text_writer #(.FILL_CHAR(8'h20), .TAB_WIDTH(8)) dut (
        .clk                  (clk),
        .clr                  (clr),
        .char_in              (char_in),
        .char_valid           (char_valid),
        .char_ready           (char_ready),
        .buffer_waddr         (buffer_waddr),
        .buffer_din           (buffer_din),
        .buffer_wen           (buffer_wen),
        .buffer_first_row     (buffer_first_row),
        .buffer_first_row_wen (buffer_first_row_wen),
        .cursor_row           (cursor_row),
        .cursor_col           (cursor_col)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Entered on a falling edge with char_ready high; returns on the falling
    // edge of the cycle after acceptance.
    task automatic send(input logic [7:0] b);
        char_in    = b;
        char_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        char_valid = 1'b0;
    endtask

    task automatic wait_ready(input string tag, input int bound);
        int n = 0;
        while (char_ready !== 1'b1 && n < bound) begin
            @(negedge clk);
            n++;
        end
        check(tag, char_ready, 1);
    endtask

    // Called at T+1 of a scroll; checks T+1..T+65 of the line clear of row r.
    task automatic check_scroll(input string tag, input logic [3:0] r, input logic [3:0] new_top);
        int bad = 0;
        check({tag, "_frwen"}, buffer_first_row_wen, 1);
        check({tag, "_frow"}, buffer_first_row, new_top);
        check({tag, "_addr0"}, {buffer_wen, buffer_waddr, buffer_din}, {1'b1, r, 6'd0, 8'h20});
        check({tag, "_rdy_lo"}, char_ready, 0);
        for (int j = 1; j < 64; j++) begin
            @(negedge clk);
            if (buffer_wen !== 1'b1 || buffer_waddr !== {r, 6'(j)} || buffer_din !== 8'h20 ||
                buffer_first_row_wen !== 1'b0 || char_ready !== 1'b0)
                bad++;
        end
        check({tag, "_clear_bad"}, bad, 0);
        @(negedge clk);
        check({tag, "_rdy_t65"}, char_ready, 1);
        check({tag, "_wen_t65"}, buffer_wen, 0);
    endtask

    initial begin
        int bad;
        clr        = 1'b1;
        char_in    = 8'h00;
        char_valid = 1'b0;
        repeat (3) @(negedge clk);

        // Reset values
        check("rst_wen", buffer_wen, 0);
        check("rst_frwen", buffer_first_row_wen, 0);
        check("rst_waddr", buffer_waddr, 0);
        check("rst_din", buffer_din, 0);
        check("rst_frow", buffer_first_row, 0);
        check("rst_cursor", {cursor_row, cursor_col}, 0);
        check("rst_ready", char_ready, 0);

        // Full-buffer clear after reset release
        clr = 1'b0;
        bad = 0;
        for (int k = 0; k < 1024; k++) begin
            @(negedge clk);
            if (buffer_wen !== 1'b1 || buffer_waddr !== 10'(k) || buffer_din !== 8'h20) bad++;
            if (k < 1023 && char_ready !== 1'b0) bad++;
        end
        check("clear_all_bad", bad, 0);
        check("clear_all_ready", char_ready, 1);
        @(negedge clk);
        check("idle_wen", buffer_wen, 0);
        check("idle_cursor", {cursor_row, cursor_col}, 0);

        // "AB", CR, "C"
        send(8'h41);
        check("A_write", {buffer_wen, buffer_waddr, buffer_din}, {1'b1, 10'h000, 8'h41});
        check("A_col", cursor_col, 1);
        send(8'h42);
        check("B_write", {buffer_wen, buffer_waddr, buffer_din}, {1'b1, 10'h001, 8'h42});
        check("B_col", cursor_col, 2);
        send(8'h0D);
        check("CR_wen", buffer_wen, 0);
        check("CR_col", cursor_col, 0);
        send(8'h43);
        check("C_write", {buffer_wen, buffer_waddr, buffer_din}, {1'b1, 10'h000, 8'h43});
        check("C_col", cursor_col, 1);

        // BS at column 0, HT stops, saturation
        send(8'h0D);
        send(8'h08);
        check("BS0_wen", buffer_wen, 0);
        check("BS0_col", cursor_col, 0);
        for (int i = 0; i < 5; i++) send(8'h61 + 8'(i));
        check("col5", cursor_col, 5);
        send(8'h09);
        check("HT5_col", cursor_col, 8);
        check("HT5_wen", buffer_wen, 0);
        for (int i = 0; i < 6; i++) send(8'h09);
        check("HT56_col", cursor_col, 56);
        for (int i = 0; i < 4; i++) send(8'h2E);
        check("col60", cursor_col, 60);
        send(8'h09);
        check("HT60_col", cursor_col, 63);
        send(8'h08);
        check("BS63_col", cursor_col, 62);
        send(8'h09);
        check("HT62_col", cursor_col, 63);
        send(8'h07);
        check("BEL_wen", buffer_wen, 0);
        check("BEL_cursor", {cursor_row, cursor_col}, {4'd0, 6'd63});
        send(8'h7F);
        check("DEL_wen", buffer_wen, 0);
        send(8'hFF);
        check("FF_wen", buffer_wen, 0);
        check("FF_cursor", {cursor_row, cursor_col}, {4'd0, 6'd63});

        // 64 printables on one line, then one more at column 63
        send(8'h0D);
        for (int i = 0; i < 64; i++) send(8'h30 + 8'(i));
        check("p64_write", {buffer_wen, buffer_waddr, buffer_din}, {1'b1, 10'h03F, 8'h6F});
        check("p64_col", cursor_col, 63);
        send(8'h21);
        check("p65_write", {buffer_wen, buffer_waddr, buffer_din}, {1'b1, 10'h03F, 8'h21});
        check("p65_cursor", {cursor_row, cursor_col}, {4'd0, 6'd63});

        // LF moves down, column kept
        send(8'h0A);
        check("LF1_wen", buffer_wen, 0);
        check("LF1_cursor", {cursor_row, cursor_col}, {4'd1, 6'd63});
        for (int i = 0; i < 14; i++) send(8'h0A);
        check("LF15_row", cursor_row, 15);
        send(8'h0D);
        send(8'h51);
        check("Q_row15", {buffer_wen, buffer_waddr, buffer_din}, {1'b1, 10'h3C0, 8'h51});

        // Scroll with first_row 0
        send(8'h0A);
        check_scroll("scr0", 4'd0, 4'd1);
        check("scr0_cursor", {cursor_row, cursor_col}, {4'd15, 6'd1});
        send(8'h0D);
        send(8'h5A);
        check("Z_write", {buffer_wen, buffer_waddr, buffer_din}, {1'b1, 10'h000, 8'h5A});

        // Scroll until first_row reaches 15, then wrap to 0
        for (int i = 0; i < 14; i++) begin
            send(8'h0A);
            wait_ready("scr_bulk_ready", 100);
        end
        check("frow15", buffer_first_row, 15);
        send(8'h0A);
        check_scroll("scr15", 4'd15, 4'd0);
        send(8'h0D);
        send(8'h59);
        check("Y_write", {buffer_wen, buffer_waddr, buffer_din}, {1'b1, 10'h3C0, 8'h59});

        // clr during a line clear
        send(8'h0A);
        check("mid_frwen", buffer_first_row_wen, 1);
        repeat (10) @(negedge clk);
        clr = 1'b1;
        #1;
        check("midclr_wen", buffer_wen, 0);
        check("midclr_waddr", buffer_waddr, 0);
        check("midclr_din", buffer_din, 0);
        check("midclr_frow", buffer_first_row, 0);
        check("midclr_cursor", {cursor_row, cursor_col}, 0);
        check("midclr_ready", char_ready, 0);
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        check("restart_write", {buffer_wen, buffer_waddr, buffer_din}, {1'b1, 10'h000, 8'h20});
        check("restart_ready", char_ready, 0);
        wait_ready("restart_done", 1100);
        @(negedge clk);

        // 17 LFs from row 0: two scrolls, first_row ends at 2
        for (int i = 0; i < 15; i++) send(8'h0A);
        check("lf17_row15", {cursor_row, buffer_first_row}, {4'd15, 4'd0});
        send(8'h0A);
        wait_ready("lf16_ready", 100);
        send(8'h0A);
        check_scroll("lf17", 4'd1, 4'd2);
        send(8'h0D);
        send(8'h57);
        check("W_write", {buffer_wen, buffer_waddr, buffer_din}, {1'b1, 10'h040, 8'h57});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
